// File: rtl/exec_io_pkg.sv
// Shared types and constants for the board input conditioner.
// Holds the debounce FSM encoding, default timing and instruction field positions.
package exec_io_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEFAULT_SYNC_STAGES     = 2;

    localparam int unsigned OP_MSB  = 14;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RS_MSB  = 7;
    localparam int unsigned RT_MSB  = 3;
    localparam int unsigned INSTR_W = OP_MSB + 1;

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: synchroniser, debounce FSM with stability counter.
// 'accept' is high for the one cycle in which a press becomes debounced.
module btn_debounce
    import exec_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int unsigned CNT_W           = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic accept,
    output logic held
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    btn_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (synced) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!synced) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!synced) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (synced) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        accept = (state_q == PRESS_WAIT) && synced && (cnt_q == CNT_LAST);
        held   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    end

endmodule

// File: rtl/exec_input_conditioner.sv
// Board front end: synchronises switches, debounces exec/reset buttons, emits one-cycle
// strobes and latches the instruction word when an exec press is accepted.
module exec_input_conditioner
    import exec_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int unsigned CNT_W           = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        sw_raw,
    input  logic               btn_exec_raw,
    input  logic               btn_reset_raw,
    output logic [OP_MSB:0]    instr,
    output logic               hi_sel,
    output logic               exec_pulse,
    output logic               reset_pulse,
    output logic               exec_held
);

    logic [15:0] sw_sync_q [SYNC_STAGES];
    logic [15:0] sw_synced;
    logic        exec_accept;
    logic        reset_accept;
    logic        reset_held;
    logic        exec_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sync_q[i] <= '0;
            end
        end else begin
            sw_sync_q[0] <= sw_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sync_q[i] <= sw_sync_q[i-1];
            end
        end
    end

    assign sw_synced = sw_sync_q[SYNC_STAGES-1];
    assign hi_sel    = sw_synced[15];

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES),
        .CNT_W           (CNT_W)
    ) u_exec_db (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_exec_raw),
        .accept  (exec_accept),
        .held    (exec_held)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES),
        .CNT_W           (CNT_W)
    ) u_reset_db (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_reset_raw),
        .accept  (reset_accept),
        .held    (reset_held)
    );

    // Reset button wins: an exec accepted alongside or during a held reset is swallowed.
    assign exec_fire = exec_accept && !reset_accept && !reset_held;

    always_ff @(posedge clk) begin
        if (reset) begin
            exec_pulse  <= 1'b0;
            reset_pulse <= 1'b0;
            instr       <= '0;
        end else begin
            exec_pulse  <= exec_fire;
            reset_pulse <= reset_accept;
            if (reset_accept) begin
                instr <= '0;
            end else if (exec_fire) begin
                instr <= sw_synced[OP_MSB:0];
            end
        end
    end

endmodule
